// File: rtl/saturn_bus_ctrl_if.sv
// saturn_bus_ctrl_if
//
// Purpose: the Saturn nibble bus as seen by the bus controller. One bus
// transfer is a single-tick strobe qualified by cmd_data and carrying
// drive_data. return_data is the nibble the bus hands back on a read.
//
// Signals:
//   strobe      bus transfer strobe
//   cmd_data    1 = command nibble, 0 = data nibble
//   drive_data  nibble driven onto the bus
//   return_data nibble returned by the bus
//
// Modports:
//   master  the bus controller (drives strobe/cmd_data/drive_data)
//   slave   the bus side (drives return_data)
interface saturn_bus_ctrl_if;
    logic       strobe;
    logic       cmd_data;
    logic [3:0] drive_data;
    logic [3:0] return_data;

    modport master (
        output strobe,
        output cmd_data,
        output drive_data,
        input  return_data
    );

    modport slave (
        input  strobe,
        input  cmd_data,
        input  drive_data,
        output return_data
    );
endinterface

// File: rtl/saturn_bus_ctrl.sv
// saturn_bus_ctrl
//
// Purpose: bus-side consumer of the control unit's bus program ring. Entries
// are 5 bits wide: bit4=1 marks a command nibble, bit4=0 a data nibble. The
// block owns the ring read pointer and puts at most one entry onto the
// Saturn nibble bus per 4-phase cycle, always on phase 0. While the ring is
// empty it issues PC_READ strobes and returns the fetched nibble. o_bus_busy
// stalls the control unit while a command sequence is queued or in flight.
//
// Optional feature macro: SATURN_BUS_STRICT_EN
//   defined     - a data entry met outside an address sequence raises the
//                 sticky o_error flag (it is still consumed, never strobed)
//   not defined - such an entry is dropped silently
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_clk_en               global clock enable; nothing moves while 0
//   i_phases               one-hot phase strobe (bit n = phase n)
//   i_phase, i_cycle_ctr   debug only, not used by the logic
//   i_program_data         ring entry at o_program_address
//   i_program_address      control unit write pointer (next free slot)
//   o_program_address      ring read pointer
//   i_no_read              suppress idle PC_READ strobes
//   o_bus_busy             command sequence pending or in flight
//   bus                    nibble bus (master side)
//   o_nibble               last nibble read from the bus
//   o_nibble_valid         one-tick pulse when o_nibble updates
//   o_error                sticky protocol error
module saturn_bus_ctrl #(
    parameter int PTR_W        = 5,
    parameter int ADDR_NIBBLES = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic [3:0]        i_phases,
    input  logic [1:0]        i_phase,
    input  logic [31:0]       i_cycle_ctr,
    input  logic [4:0]        i_program_data,
    input  logic [PTR_W-1:0]  i_program_address,
    output logic [PTR_W-1:0]  o_program_address,
    input  logic              i_no_read,
    output logic              o_bus_busy,
    saturn_bus_ctrl_if.master bus,
    output logic [3:0]        o_nibble,
    output logic              o_nibble_valid,
    output logic              o_error
);

    localparam logic [3:0] CMD_LOAD_PC = 4'h4;
    localparam logic [3:0] CMD_LOAD_DP = 4'h5;
    localparam int         CNT_W       = $clog2(ADDR_NIBBLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_ADDR,
        S_CMD_DONE
    } state_t;

    state_t           state, state_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] nib_cnt, nib_cnt_next;
    logic             strobe_q, strobe_next;
    logic             cmd_data_q, cmd_data_next;
    logic [3:0]       drive_q, drive_next;
    logic [3:0]       nibble_next;
    logic             valid_next;
    logic             error_next;
    logic             busy_next;
    logic             pending;
    logic             is_cmd;
    logic             is_addr_cmd;
    logic             unused_debug;

    assign pending     = (o_program_address != i_program_address);
    assign is_cmd      = i_program_data[4];
    assign is_addr_cmd = (i_program_data[3:0] == CMD_LOAD_PC) ||
                         (i_program_data[3:0] == CMD_LOAD_DP);

    assign bus.strobe     = strobe_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.drive_data = drive_q;

    assign unused_debug = ^{i_phase, i_cycle_ctr, i_phases[2]};

    // Next-state and next-output logic. Strobes and the valid pulse default
    // low so they last exactly one enabled tick; everything else holds.
    // Busy is computed from the post-update pointer and state so it falls
    // on the same tick the sequence closes. READ is an idle-time fetch, not
    // a command sequence, so it does not count as busy.
    always_comb begin
        state_next    = state;
        rd_ptr_next   = o_program_address;
        nib_cnt_next  = nib_cnt;
        strobe_next   = 1'b0;
        cmd_data_next = cmd_data_q;
        drive_next    = drive_q;
        nibble_next   = o_nibble;
        valid_next    = 1'b0;
        error_next    = o_error;

        case (state)
            S_IDLE: begin
                if (i_phases[0]) begin
                    if (pending) begin
                        rd_ptr_next = o_program_address + 1'b1;
                        if (is_cmd) begin
                            strobe_next   = 1'b1;
                            cmd_data_next = 1'b1;
                            drive_next    = i_program_data[3:0];
                            if (is_addr_cmd) begin
                                state_next   = S_ADDR;
                                nib_cnt_next = '0;
                            end else begin
                                state_next = S_CMD_DONE;
                            end
                        end else begin
`ifdef SATURN_BUS_STRICT_EN
                            error_next = 1'b1;
`else
                            error_next = o_error;
`endif
                        end
                    end else if (!i_no_read) begin
                        strobe_next   = 1'b1;
                        cmd_data_next = 1'b0;
                        drive_next    = 4'h0;
                        state_next    = S_READ;
                    end
                end
            end
            S_READ: begin
                if (i_phases[1]) begin
                    nibble_next = bus.return_data;
                    valid_next  = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_ADDR: begin
                if (i_phases[0] && pending) begin
                    rd_ptr_next = o_program_address + 1'b1;
                    if (is_cmd) begin
                        error_next = 1'b1;
                    end else begin
                        strobe_next   = 1'b1;
                        cmd_data_next = 1'b0;
                        drive_next    = i_program_data[3:0];
                        nib_cnt_next  = nib_cnt + 1'b1;
                        if (nib_cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
                            state_next = S_CMD_DONE;
                        end
                    end
                end
            end
            S_CMD_DONE: begin
                if (i_phases[3]) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (rd_ptr_next != i_program_address) ||
                    (state_next == S_ADDR) || (state_next == S_CMD_DONE);
    end

    // State and registered outputs. Reset abandons any sequence in flight
    // and clears every output at once; i_clk_en=0 freezes everything,
    // including a valid pulse that is still high.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= S_IDLE;
            o_program_address <= '0;
            nib_cnt           <= '0;
            strobe_q          <= 1'b0;
            cmd_data_q        <= 1'b0;
            drive_q           <= 4'h0;
            o_nibble          <= 4'h0;
            o_nibble_valid    <= 1'b0;
            o_error           <= 1'b0;
            o_bus_busy        <= 1'b0;
        end else if (i_clk_en) begin
            state             <= state_next;
            o_program_address <= rd_ptr_next;
            nib_cnt           <= nib_cnt_next;
            strobe_q          <= strobe_next;
            cmd_data_q        <= cmd_data_next;
            drive_q           <= drive_next;
            o_nibble          <= nibble_next;
            o_nibble_valid    <= valid_next;
            o_error           <= error_next;
            o_bus_busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// tb_saturn_bus_ctrl
//
// Purpose: self-checking bench for saturn_bus_ctrl. A ring memory and the
// phase generator live here; a bus-cycle level reference model (a queue
// view of the ring plus "sequence open" / "address nibbles left" counters)
// predicts every output after each clock. Directed scenarios run first,
// then a randomized stretch with gated clock enable.
module tb_saturn_bus_ctrl;

`ifdef SATURN_BUS_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [3:0]  phases;
    logic [1:0]  phase;
    logic [31:0] cycle_ctr;
    logic [4:0]  program_data;
    logic [4:0]  wr_ptr;
    logic [4:0]  rd_out;
    logic        no_read;
    logic        busy;
    logic [3:0]  nibble;
    logic        valid;
    logic        error;
    logic [3:0]  bus_rdata;
    logic [4:0]  ring [32];

    saturn_bus_ctrl_if bus_if ();

    assign bus_if.return_data = bus_rdata;
    assign program_data       = ring[rd_out];

    saturn_bus_ctrl dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_clk_en          (clk_en),
        .i_phases          (phases),
        .i_phase           (phase),
        .i_cycle_ctr       (cycle_ctr),
        .i_program_data    (program_data),
        .i_program_address (wr_ptr),
        .o_program_address (rd_out),
        .i_no_read         (no_read),
        .o_bus_busy        (busy),
        .bus               (bus_if),
        .o_nibble          (nibble),
        .o_nibble_valid    (valid),
        .o_error           (error)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;

    int         phase_idx;
    logic [4:0] m_rd;
    bit         in_seq;
    int         addr_left;
    bit         read_due;
    bit         rand_en;
    logic       exp_strobe;
    logic       exp_cmd;
    logic       exp_valid;
    logic       exp_error;
    logic       exp_busy;
    logic       data_known;
    logic [3:0] exp_data;
    logic [3:0] exp_nibble;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one call per enabled clock, phase_idx is the phase the
    // DUT saw on that edge. Phase 0 decides this cycle's bus transfer from
    // the queued entries; phase 1 completes a read; phase 3 closes a
    // sequence that has no address nibbles left.
    task automatic modelStep();
        logic [4:0] e;
        exp_strobe = 1'b0;
        exp_valid  = 1'b0;
        case (phase_idx)
            0: begin
                if (!in_seq) begin
                    if (m_rd != wr_ptr) begin
                        e    = ring[m_rd];
                        m_rd = m_rd + 5'd1;
                        if (e[4]) begin
                            exp_strobe = 1'b1;
                            exp_cmd    = 1'b1;
                            exp_data   = e[3:0];
                            data_known = 1'b1;
                            in_seq     = 1'b1;
                            addr_left  = (e[3:0] == 4'h4 || e[3:0] == 4'h5) ? 5 : 0;
                        end else if (STRICT) begin
                            exp_error = 1'b1;
                        end
                    end else if (!no_read) begin
                        exp_strobe = 1'b1;
                        exp_cmd    = 1'b0;
                        data_known = 1'b0;
                        read_due   = 1'b1;
                    end
                end else if (addr_left > 0 && m_rd != wr_ptr) begin
                    e    = ring[m_rd];
                    m_rd = m_rd + 5'd1;
                    if (e[4]) begin
                        exp_error = 1'b1;
                    end else begin
                        exp_strobe = 1'b1;
                        exp_cmd    = 1'b0;
                        exp_data   = e[3:0];
                        data_known = 1'b1;
                        addr_left--;
                    end
                end
            end
            1: begin
                if (read_due) begin
                    exp_nibble = bus_rdata;
                    exp_valid  = 1'b1;
                    read_due   = 1'b0;
                end
            end
            3: begin
                if (in_seq && addr_left == 0) in_seq = 1'b0;
            end
            default: ;
        endcase
        exp_busy = (m_rd != wr_ptr) || in_seq;
    endtask

    task automatic compareAll();
        checkOutput("prog_addr", 32'(rd_out), 32'(m_rd));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("strobe", 32'(bus_if.strobe), 32'(exp_strobe));
        if (exp_strobe) checkOutput("cmd_data", 32'(bus_if.cmd_data), 32'(exp_cmd));
        if (exp_strobe && data_known) checkOutput("bus_data", 32'(bus_if.drive_data), 32'(exp_data));
        checkOutput("nibble", 32'(nibble), 32'(exp_nibble));
        checkOutput("nibble_valid", 32'(valid), 32'(exp_valid));
        checkOutput("error", 32'(error), 32'(exp_error));
    endtask

    // One clock: let the DUT take the edge, advance the model, compare,
    // then present the next tick's phase and enable.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (clk_en) begin
            modelStep();
            phase_idx = (phase_idx + 1) % 4;
        end
        compareAll();
        cycle_ctr = cycle_ctr + 32'd1;
        clk_en    = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        phases    = 4'b0001 << phase_idx;
        phase     = 2'(phase_idx);
    endtask

    task automatic runTicks(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic pushEntry(input logic [4:0] e);
        ring[wr_ptr] = e;
        wr_ptr       = wr_ptr + 5'd1;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_prog_addr", 32'(rd_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_strobe", 32'(bus_if.strobe), 32'd0);
        checkOutput("rst_cmd_data", 32'(bus_if.cmd_data), 32'd0);
        checkOutput("rst_bus_data", 32'(bus_if.drive_data), 32'd0);
        checkOutput("rst_nibble", 32'(nibble), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wr_ptr     = 5'd0;
        m_rd       = 5'd0;
        in_seq     = 1'b0;
        addr_left  = 0;
        read_due   = 1'b0;
        exp_strobe = 1'b0;
        exp_cmd    = 1'b0;
        exp_valid  = 1'b0;
        exp_error  = 1'b0;
        exp_busy   = 1'b0;
        exp_data   = 4'h0;
        exp_nibble = 4'h0;
        data_known = 1'b0;
        phase_idx  = 0;
        phases     = 4'b0001;
        phase      = 2'd0;
        clk_en     = 1'b1;
        rst        = 1'b0;
    endtask

    function automatic logic [4:0] randomEntry();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'h14;
        if (r == 1) return 5'h15;
        if (r == 2) return {1'b1, 4'($urandom)};
        return {1'b0, 4'($urandom)};
    endfunction

    // Directed scenarios followed by a randomized run.
    initial begin
        int valid_count;
        int guard;
        for (int i = 0; i < 32; i++) ring[i] = 5'd0;
        rand_en   = 1'b0;
        no_read   = 1'b0;
        bus_rdata = 4'hA;
        cycle_ctr = 32'd0;
        clk_en    = 1'b1;
        phases    = 4'b0001;
        phase     = 2'd0;
        wr_ptr    = 5'd0;
        doReset();

        // Empty ring: one PC_READ per bus cycle, nibble 4'hA each time.
        valid_count = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (valid) valid_count++;
        end
        checkOutput("idle_valid_pulses", 32'(valid_count), 32'd10);
        checkOutput("idle_nibble", 32'(nibble), 32'hA);

        // LOAD_PC with all five address nibbles written at once.
        pushEntry(5'h14);
        for (int i = 0; i < 5; i++) pushEntry(5'(i));
        runTicks(40);
        checkOutput("loadpc_rd_ptr", 32'(rd_out), 32'd6);
        checkOutput("loadpc_busy_end", 32'(busy), 32'd0);

        // LOAD_PC with address nibbles trickling in every three bus cycles.
        pushEntry(5'h14);
        for (int i = 0; i < 5; i++) begin
            runTicks(12);
            pushEntry(5'(i + 5));
        end
        runTicks(40);
        checkOutput("slow_rd_ptr", 32'(rd_out), 32'd12);

        // Walk the pointer to 30 with single commands, then wrap a LOAD_DP.
        for (int i = 0; i < 18; i++) pushEntry(5'h18);
        runTicks(18 * 4 + 8);
        checkOutput("pre_wrap_rd_ptr", 32'(rd_out), 32'd30);
        pushEntry(5'h15);
        for (int i = 0; i < 5; i++) pushEntry(5'(9 - i));
        runTicks(40);
        checkOutput("wrap_rd_ptr", 32'(rd_out), 32'd4);

        // Reset right after the third address nibble is strobed.
        pushEntry(5'h14);
        for (int i = 0; i < 5; i++) pushEntry(5'(i + 1));
        guard = 0;
        while (!(exp_strobe && in_seq && addr_left == 2) && guard < 100) begin
            applyStimulus();
            guard++;
        end
        checkOutput("reset_point_timeout", 32'(guard >= 100), 32'd0);
        doReset();
        runTicks(12);
        checkOutput("post_reset_rd_ptr", 32'(rd_out), 32'd0);

        // Stray data entry while idle.
        pushEntry(5'h07);
        runTicks(16);
        checkOutput("stray_data_error", 32'(error), 32'(STRICT));

        // Randomized traffic with gated clock enable.
        rand_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            if ($urandom_range(0, 3) == 0 && 5'(wr_ptr - m_rd) < 5'd28) pushEntry(randomEntry());
            if ($urandom_range(0, 15) == 0) no_read = ~no_read;
            if ($urandom_range(0, 3) == 0) bus_rdata = 4'($urandom);
        end
        no_read = 1'b0;
        runTicks(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
